mem_port_arbiter: RTL and testbench
===================================

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters: ADDR_W, default 16, memory address width; DATA_W, default 8, pixel data width; MAX_HOLD, default 16, hold-limit cycle count.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 req0, req1  input  1 each  access request; requester 0 = upsampling engine, requester 1 = host loader.
REQ-005 lock0, lock1  input  1 each  keep grant across consecutive accesses (burst).
REQ-006 addr0, addr1  input  ADDR_W each  access address.
REQ-007 wdata0, wdata1  input  DATA_W each  write data.
REQ-008 wren0, wren1  input  1 each  1 = write, 0 = read.
REQ-009 gnt0, gnt1  output  1 each  grant, registered, one-hot or zero.
REQ-010 mem_en, mem_wren  output  1 each  memory enable and write enable.
REQ-011 mem_addr, mem_wdata  output  ADDR_W, DATA_W  muxed memory address and write data.
REQ-012 mem_rdata  input  DATA_W  memory read data, valid one cycle after a read.
REQ-013 rdata  output  DATA_W  mem_rdata passed through to both requesters.
REQ-014 rvalid0, rvalid1  output  1 each  one-cycle pulse marking rdata valid for that requester.
REQ-015 hold_viol  output  1  sticky flag: lock was overridden by the hold limit.

Function
REQ-016 FSM states: IDLE, GNT0, GNT1; gnt0 = (state==GNT0), gnt1 = (state==GNT1).
REQ-017 Accepted access: cycle with state GNTx and reqx=1; mem_en=1 and mem_addr/mem_wdata/mem_wren taken from requester x, combinationally in that cycle.
REQ-018 Outside accepted accesses, mem_en=0, mem_wren=0, mem_addr=0 and mem_wdata=0.
REQ-019 IDLE: only reqx -> GNTx; both -> requester other than last_grant; none -> IDLE.
REQ-020 Request-to-grant latency is one cycle; no combinational path from any req to any gnt.
REQ-021 GNTx with reqx=0: other requester pending -> GNTother; else -> IDLE.
REQ-022 GNTx with reqx=1 and lockx=1 -> stay GNTx, no gap cycles in the burst.
REQ-023 GNTx with reqx=1, lockx=0, other pending -> GNTother after this access; other not pending -> stay GNTx.
REQ-024 last_grant is updated to x on every entry into GNTx.
REQ-025 rvalidx=1 exactly one cycle after an accepted read by x; a write never produces rvalid.
REQ-026 When a grant switches, a read issued in the last cycle of the old grant still pulses rvalid of the old owner on the following cycle.

Reset
REQ-027 Reset asserted: state=IDLE, last_grant=1 (requester 0 wins first tie), gnt0=gnt1=0, rvalid0=rvalid1=0, hold counter=0, hold_viol=0, mem_en=mem_wren=0.
REQ-028 Reset mid-burst aborts the burst immediately; a read pending its rvalid pulse is dropped.

Configuration
REQ-029 Macro ARB_HOLD_LIMIT_EN defined: a counter counts consecutive accepted accesses by the current owner and clears on any grant change or when the owner drops its request.
REQ-030 With ARB_HOLD_LIMIT_EN defined: when the count reaches MAX_HOLD with the other requester pending, the grant switches despite lock, and hold_viol is set until reset.
REQ-031 ARB_HOLD_LIMIT_EN undefined: no counter exists, lock is honoured indefinitely and hold_viol is tied to 0.

Structure
REQ-032 Package mem_arb_pkg holds the FSM state encoding and the requester index constants REQ_UPS=0 and REQ_HOST=1.
REQ-033 Sub-module mem_arb_hold_counter implements the hold counter and is instantiated only under ARB_HOLD_LIMIT_EN; all other logic is in mem_port_arbiter.

Verification
REQ-034 Reset, then req0=1 only -> gnt0=1 on the next cycle; write addr0=0x0010, wdata0=0xA5 -> mem_addr=0x0010, mem_wdata=0xA5, mem_wren=1 in the same cycle.
REQ-035 req0 and req1 rise together from IDLE, lock=0, held high for 4 cycles -> grants alternate GNT0,GNT1,GNT0,GNT1.
REQ-036 GNT1 with lock1=1 for a 6-access burst while req0 waits -> gnt1 held 6 cycles with no gap, then GNT0 on the next cycle.
REQ-037 Read by requester 0 at addr 0x0003 with memory returning 0x5C -> rvalid0=1 and rdata=0x5C one cycle later, rvalid1 stays 0.
REQ-038 With ARB_HOLD_LIMIT_EN and MAX_HOLD=4: lock0 held and req1 pending -> switch to GNT1 after 4 accesses and hold_viol=1; without the macro, gnt0 is held for the whole burst.
REQ-039 Reset asserted during a GNT0 read -> gnt0=0 and mem_en=0 immediately, and no rvalid0 pulse follows.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port memory arbiter.
// Requester 0 is the upsampling engine, requester 1 the host loader.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    GNT0 = 2'b01,
    GNT1 = 2'b10
  } arb_state_t;

  localparam logic REQ_UPS  = 1'b0;
  localparam logic REQ_HOST = 1'b1;

endpackage

// File: rtl/mem_arb_hold_counter.sv
// Counts consecutive accepted accesses by the current grant owner.
// at_limit flags the access that brings the count to MAX_HOLD.
module mem_arb_hold_counter #(
  parameter int MAX_HOLD = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic acc,
  input  logic clr,
  output logic at_limit
);

  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (acc && (cnt != CW'(MAX_HOLD))) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign at_limit = acc && (cnt >= CW'(MAX_HOLD - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester memory port arbiter with burst lock and round-robin ties.
// Define ARB_HOLD_LIMIT_EN to cap lock bursts at MAX_HOLD accesses.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic              lock0,
  input  logic              lock1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  input  logic              wren0,
  input  logic              wren1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              mem_en,
  output logic              mem_wren,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic              hold_viol
);

  arb_state_t state;
  arb_state_t state_nxt;
  arb_state_t other;
  logic       last_grant;
  logic       acc0;
  logic       acc1;
  logic       own_req;
  logic       own_lock;
  logic       oth_req;
  logic       limit;
  logic       switching;

  assign gnt0 = (state == GNT0);
  assign gnt1 = (state == GNT1);
  assign acc0 = gnt0 && req0;
  assign acc1 = gnt1 && req1;

  assign own_req  = gnt1 ? req1  : req0;
  assign own_lock = gnt1 ? lock1 : lock0;
  assign oth_req  = gnt1 ? req0  : req1;
  assign other    = gnt1 ? GNT0  : GNT1;

  assign switching = (state_nxt != state);

  always_comb begin
    mem_en    = acc0 || acc1;
    mem_wren  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (acc0) begin
      mem_wren  = wren0;
      mem_addr  = addr0;
      mem_wdata = wdata0;
    end else if (acc1) begin
      mem_wren  = wren1;
      mem_addr  = addr1;
      mem_wdata = wdata1;
    end
  end

  assign rdata = mem_rdata;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          (req0 && req1):
            state_nxt = (last_grant == REQ_HOST) ? GNT0 : GNT1;
          (req0 && !req1): state_nxt = GNT0;
          (!req0 && req1): state_nxt = GNT1;
          default:         state_nxt = IDLE;
        endcase
      end
      GNT0, GNT1: begin
        if (!own_req) begin
          state_nxt = oth_req ? other : IDLE;
        end else if (oth_req && (!own_lock || limit)) begin
          state_nxt = other;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= REQ_HOST;
      rvalid0    <= 1'b0;
      rvalid1    <= 1'b0;
    end else begin
      state   <= state_nxt;
      rvalid0 <= acc0 && !wren0;
      rvalid1 <= acc1 && !wren1;
      if (switching && (state_nxt == GNT0)) begin
        last_grant <= REQ_UPS;
      end else if (switching && (state_nxt == GNT1)) begin
        last_grant <= REQ_HOST;
      end
    end
  end

`ifdef ARB_HOLD_LIMIT_EN
  mem_arb_hold_counter #(
    .MAX_HOLD(MAX_HOLD)
  ) u_hold (
    .clk     (clk),
    .reset   (reset),
    .acc     (acc0 || acc1),
    .clr     (switching),
    .at_limit(limit)
  );

  // Only a lock that was actually overridden counts as a violation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_viol <= 1'b0;
    end else if (limit && own_lock && oth_req) begin
      hold_viol <= 1'b1;
    end
  end
`else
  assign limit     = 1'b0;
  assign hold_viol = 1'b0;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios
// plus a randomized run against a cycle-level reference model.
module tb_mem_port_arbiter;

  localparam int AW = 16;
  localparam int DW = 8;
  localparam int MH = 4;
`ifdef ARB_HOLD_LIMIT_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic          clk;
  logic          reset;
  logic          req0, req1, lock0, lock1, wren0, wren1;
  logic [AW-1:0] addr0, addr1, mem_addr;
  logic [DW-1:0] wdata0, wdata1, mem_wdata, mem_rdata, rdata;
  logic          gnt0, gnt1, mem_en, mem_wren;
  logic          rvalid0, rvalid1, hold_viol;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .req1(req1), .lock0(lock0), .lock1(lock1),
    .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .wren0(wren0), .wren1(wren1),
    .gnt0(gnt0), .gnt1(gnt1),
    .mem_en(mem_en), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .rdata(rdata),
    .rvalid0(rvalid0), .rvalid1(rvalid1),
    .hold_viol(hold_viol)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive_idle();
    req0 = 0; req1 = 0; lock0 = 0; lock1 = 0;
    wren0 = 0; wren1 = 0;
    addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0;
    mem_rdata = '0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive_idle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    req0 = 1; req1 = 1; wren0 = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1, mem_en, mem_wren, rvalid0, rvalid1, hold_viol} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 0000000",
        {gnt0, gnt1, mem_en, mem_wren, rvalid0, rvalid1, hold_viol});
    end
    #1 reset = 1'b0;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL reset_first_tie: got %b want 10", {gnt0, gnt1});
    end
    drive_idle();
  endtask

  task automatic test_write();
    do_reset();
    req0 = 1; wren0 = 1; addr0 = 16'h0010; wdata0 = 8'hA5;
    @(negedge clk);
    checks++;
    if (gnt0 !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL write_latency: gnt0=%b mem_en=%b want 0 0", gnt0, mem_en);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if ({gnt0, mem_en, mem_wren, mem_addr, mem_wdata} !== {3'b111, 16'h0010, 8'hA5}) begin
      errors++;
      $display("FAIL write_access: got g=%b en=%b we=%b a=%h d=%h want 1 1 1 0010 a5",
        gnt0, mem_en, mem_wren, mem_addr, mem_wdata);
    end
    next_cycle();
    req0 = 0;
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wren, mem_addr, mem_wdata, rvalid0} !== '0) begin
      errors++;
      $display("FAIL write_idle_bus: en=%b we=%b a=%h d=%h rv0=%b want all 0",
        mem_en, mem_wren, mem_addr, mem_wdata, rvalid0);
    end
    drive_idle();
  endtask

  task automatic test_alternate();
    do_reset();
    req0 = 1; req1 = 1;
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      @(negedge clk);
      checks++;
      if ({gnt0, gnt1} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL alternate_%0d: got %b want %b", i, {gnt0, gnt1},
          (i % 2 == 0) ? 2'b10 : 2'b01);
      end
    end
    drive_idle();
  endtask

  task automatic test_burst();
    int len;
    len = HOLD_EN ? MH : 6;
    do_reset();
    req1 = 1; lock1 = 1; wren1 = 1;
    for (int i = 1; i <= len; i++) begin
      next_cycle();
      req0 = 1;
      addr1 = AW'(i);
      if (i == len) lock1 = 0;
      @(negedge clk);
      checks++;
      if ({gnt1, mem_en, mem_addr} !== {2'b11, AW'(i)}) begin
        errors++;
        $display("FAIL burst_%0d: gnt1=%b en=%b a=%h want 1 1 %h",
          i, gnt1, mem_en, mem_addr, AW'(i));
      end
    end
    next_cycle();
    req1 = 0;
    @(negedge clk);
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("FAIL burst_handover: got %b want 10", {gnt0, gnt1});
    end
    drive_idle();
  endtask

  task automatic test_read();
    do_reset();
    req0 = 1; wren0 = 0; addr0 = 16'h0003;
    next_cycle();
    @(negedge clk);
    checks++;
    if ({mem_en, mem_wren, mem_addr} !== {2'b10, 16'h0003}) begin
      errors++;
      $display("FAIL read_issue: en=%b we=%b a=%h want 1 0 0003",
        mem_en, mem_wren, mem_addr);
    end
    next_cycle();
    req0 = 0; mem_rdata = 8'h5C;
    @(negedge clk);
    checks++;
    if ({rvalid0, rvalid1, rdata} !== {2'b10, 8'h5C}) begin
      errors++;
      $display("FAIL read_return: rv0=%b rv1=%b rd=%h want 1 0 5c",
        rvalid0, rvalid1, rdata);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (rvalid0 !== 1'b0) begin
      errors++;
      $display("FAIL read_pulse_width: rv0=%b want 0", rvalid0);
    end
    drive_idle();
  endtask

  task automatic test_hold();
    int n;
    logic want;
    n = HOLD_EN ? MH + 1 : 10;
    do_reset();
    req0 = 1; lock0 = 1; wren0 = 1;
    for (int i = 1; i <= n; i++) begin
      next_cycle();
      req1 = 1;
      @(negedge clk);
      want = HOLD_EN ? (i <= MH) : 1'b1;
      checks++;
      if ({gnt0, gnt1} !== {want, ~want}) begin
        errors++;
        $display("FAIL hold_cycle_%0d: got %b want %b", i, {gnt0, gnt1}, {want, ~want});
      end
    end
    checks++;
    if (hold_viol !== HOLD_EN) begin
      errors++;
      $display("FAIL hold_viol: got %b want %b", hold_viol, HOLD_EN);
    end
    drive_idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    req0 = 1; wren0 = 0; addr0 = 16'h0007;
    next_cycle();
    @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({gnt0, mem_en} !== 2'b00) begin
      errors++;
      $display("FAIL reset_mid_abort: gnt0=%b en=%b want 0 0", gnt0, mem_en);
    end
    req0 = 0;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (rvalid0 !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_rvalid_%0d: rv0=%b want 0", i, rvalid0);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  task automatic test_random();
    int owner, last, run, nxt;
    bit viol, rv0, rv1, acc, limit;
    bit r0, r1, own_r, own_l, oth_r;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    bit ew;
    do_reset();
    owner = -1; last = 1; run = 0; viol = 0; rv0 = 0; rv1 = 0;
    for (int c = 0; c < 400; c++) begin
      req0 = ($urandom_range(0, 3) != 0);
      req1 = ($urandom_range(0, 3) != 0);
      lock0 = ($urandom_range(0, 3) != 0);
      lock1 = $urandom_range(0, 1);
      wren0 = $urandom_range(0, 1);
      wren1 = $urandom_range(0, 1);
      addr0 = AW'($urandom); addr1 = AW'($urandom);
      wdata0 = DW'($urandom); wdata1 = DW'($urandom);
      mem_rdata = DW'($urandom);
      @(negedge clk);
      r0 = req0; r1 = req1;
      acc = (owner == 0 && r0) || (owner == 1 && r1);
      ew = acc && (owner == 0 ? wren0 : wren1);
      ea = acc ? (owner == 0 ? addr0 : addr1) : '0;
      ed = acc ? (owner == 0 ? wdata0 : wdata1) : '0;
      checks++;
      if ({gnt0, gnt1} !== {owner == 0, owner == 1}) begin
        errors++;
        $display("FAIL rand_gnt c%0d: got %b want %b", c, {gnt0, gnt1},
          {owner == 0, owner == 1});
      end
      checks++;
      if ({mem_en, mem_wren, mem_addr, mem_wdata} !== {acc, ew, ea, ed}) begin
        errors++;
        $display("FAIL rand_bus c%0d: got %b %b %h %h want %b %b %h %h", c,
          mem_en, mem_wren, mem_addr, mem_wdata, acc, ew, ea, ed);
      end
      checks++;
      if ({rvalid0, rvalid1, rdata, hold_viol} !== {rv0, rv1, mem_rdata, viol}) begin
        errors++;
        $display("FAIL rand_rsp c%0d: got rv=%b%b rd=%h hv=%b want rv=%b%b rd=%h hv=%b",
          c, rvalid0, rvalid1, rdata, hold_viol, rv0, rv1, mem_rdata, viol);
      end
      rv0 = acc && owner == 0 && !wren0;
      rv1 = acc && owner == 1 && !wren1;
      if (owner < 0) begin
        if (r0 && r1) nxt = (last == 1) ? 0 : 1;
        else if (r0) nxt = 0;
        else if (r1) nxt = 1;
        else nxt = -1;
      end else begin
        own_r = (owner == 0) ? r0 : r1;
        own_l = (owner == 0) ? lock0 : lock1;
        oth_r = (owner == 0) ? r1 : r0;
        limit = HOLD_EN && (run + 1 >= MH);
        nxt = owner;
        if (!own_r) nxt = oth_r ? 1 - owner : -1;
        else if (oth_r && (!own_l || limit)) nxt = 1 - owner;
        if (own_r && own_l && oth_r && limit) viol = 1;
      end
      if (nxt != owner) run = 0;
      else if (acc) run++;
      if (nxt >= 0 && nxt != owner) last = nxt;
      owner = nxt;
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_write();
    test_alternate();
    test_burst();
    test_read();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
